mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while fetch waits before fetch is forced.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  fetch read request; held until i_ack.
REQ-006 i_addr  input  AW  fetch word address.
REQ-007 i_ack  output  1  one-cycle pulse; i_rdata valid in the same cycle.
REQ-008 i_rdata  output  32  fetched instruction; held until next i_ack.
REQ-009 d_req  input  1  data request; held until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  AW  data address.
REQ-012 d_wdata  input  32  store data, already lane-aligned.
REQ-013 d_byteen  input  4  store byte enables.
REQ-014 d_ack  output  1  one-cycle pulse, for loads and stores.
REQ-015 d_rdata  output  32  load data; held until next d_ack.
REQ-016 mem_req  output  1  request to the shared memory port.
REQ-017 mem_we  output  1  write strobe, qualified by mem_req.
REQ-018 mem_addr  output  AW  latched address.
REQ-019 mem_wdata  output  32  latched store data.
REQ-020 mem_byteen  output  4  latched byte enables; 4'b0000 for reads.
REQ-021 mem_gnt  input  1  port accepts the request this cycle.
REQ-022 mem_rvalid  input  1  completion; mem_rdata valid.
REQ-023 mem_rdata  input  32  read data.
REQ-024 busy  output  1  high whenever state is not IDLE; feeds the stall unit.

Function
REQ-025 FSM states IDLE, REQ, WAIT, DONE.
- IDLE->REQ when i_req|d_req.
- REQ->WAIT when mem_gnt.
- WAIT->DONE when mem_rvalid.
- DONE->IDLE unconditionally.
REQ-026 On IDLE->REQ, the owner and the request fields (addr, we, wdata, byteen) shall be latched; mem_* outputs come from these registers only.
REQ-027 mem_req shall be high exactly in REQ; mem_we = latched we & mem_req.
REQ-028 Arbitration: data wins a simultaneous request unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-029 starve_cnt update rules:
- increments (saturating at STARVE_MAX) on each data grant while i_req = 1;
- clears on fetch grant;
- clears in any IDLE cycle with i_req = 0.
REQ-030 Completion and acks:
- mem_rdata shall be registered into the owner's rdata register on WAIT->DONE.
- The owner's ack is high only in DONE.
- Stores return rdata unchanged.
REQ-031 Minimum latency: req high in cycle 0, mem_gnt in cycle 1, mem_rvalid in cycle 2 -> ack in cycle 3.
REQ-032 A requester dropping req mid-transaction shall not abort; its ack still pulses.
REQ-033 mem_gnt outside REQ and mem_rvalid outside WAIT shall be ignored.
REQ-034 Back-to-back: the earliest next grant is the IDLE cycle following DONE, so no double issue occurs on a still-held req.
REQ-035 i_ack and d_ack shall never be high in the same cycle.

Reset
REQ-036 While reset = 0, asynchronously, the following shall hold: state = IDLE, mem_req = mem_we = 0, mem_addr = mem_wdata = 0, mem_byteen = 0, i_ack = d_ack = 0, i_rdata = d_rdata = 0, starve_cnt = 0, busy = 0.
REQ-037 Reset mid-transaction shall discard the transaction without an ack; the first request after release is arbitrated fresh.

Structure
REQ-038 State encodings and owner encoding (OWN_I, OWN_D) shall live in the shared constants header used by the pipeline.
REQ-039 The starvation counter shall be a sub-module arb_starve_cnt with inputs grant_d, grant_i, i_req and output at_max.

Verification
REQ-040 Single fetch: i_req = 1, i_addr = 0x3000, mem_gnt same cycle, mem_rvalid one cycle later with 0x24010001 -> i_ack in cycle 3, i_rdata = 0x24010001, mem_byteen = 0.
REQ-041 Store: d_req = 1, d_we = 1, d_addr = 0x10, d_wdata = 0x0000AB00, d_byteen = 4'b0010 -> mem_we = 1 and fields match while in REQ; d_ack pulses once; d_rdata unchanged.
REQ-042 Contention: i_req and d_req held continuously -> grants D, D, D, D, I, D, ... (STARVE_MAX = 4); acks never overlap.
REQ-043 Stalled port: mem_gnt low for 5 cycles, then mem_rvalid delayed 3 cycles -> mem_req is high exactly 6 cycles, busy stays high, a single ack, and spurious mem_rvalid during REQ is ignored.
REQ-044 Reset in WAIT: reset = 0 for 1 cycle -> all outputs 0 immediately, no ack; a subsequent i_req is served normally.
REQ-045 Held req after ack: i_req kept high through DONE -> exactly one new transaction per DONE->IDLE->REQ sequence, not two.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and bus-owner encodings for the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: counts data grants taken while fetch waits; at_max forces a fetch grant
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic grant_d,
    input  logic grant_i,
    input  logic i_req,
    output logic at_max
);
    localparam int CW = $clog2(STARVE_MAX + 2);
    logic [CW-1:0] cnt;
    assign at_max = cnt == CW'(STARVE_MAX);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (grant_i || (idle && !i_req))
            cnt <= '0;
        else if (grant_d && !at_max)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arb.sv
// mem_arb: two-requester (fetch/data) arbiter for a single shared memory port
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_byteen,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_byteen,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);
    state_t state, state_nx;
    owner_t owner;
    logic   we, grant, own_d, at_max;
    assign grant = state == IDLE && (i_req || d_req);
    assign own_d = d_req && !(i_req && at_max);
    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk     (clk),
        .reset   (reset),
        .idle    (state == IDLE),
        .grant_d (grant && own_d),
        .grant_i (grant && !own_d),
        .i_req   (i_req),
        .at_max  (at_max)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (i_req || d_req) ? REQ : IDLE;
            REQ:     state_nx = mem_gnt ? WAIT : REQ;
            WAIT:    state_nx = mem_rvalid ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
        mem_req = state == REQ;
        mem_we  = we && mem_req;
        busy    = state != IDLE;
        i_ack   = state == DONE && owner == OWN_I;
        d_ack   = state == DONE && owner == OWN_D;
    end
    // request fields are captured once at grant; the port sees only these registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= OWN_I;
            we         <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_byteen <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (grant) begin
                owner      <= own_d ? OWN_D : OWN_I;
                we         <= own_d && d_we;
                mem_addr   <= own_d ? d_addr : i_addr;
                mem_wdata  <= own_d ? d_wdata : '0;
                mem_byteen <= (own_d && d_we) ? d_byteen : 4'b0000;
            end
            if (state == WAIT && mem_rvalid && !we) begin
                if (owner == OWN_D)
                    d_rdata <= mem_rdata;
                else
                    i_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed vector table plus scripted multi-cycle sequences for mem_arb
module tb_mem_arb;
    logic        clk = 0, reset = 0;
    logic        i_req = 0, d_req = 0, d_we = 0, mem_gnt = 0, mem_rvalid = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_byteen = 0;
    logic        i_ack, d_ack, mem_req, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    mem_arb #(.STARVE_MAX(4), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteen(d_byteen), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic        ir, dr, dw;
        logic [31:0] ia, da, dwd;
        logic [3:0]  be;
        logic        g, rv;
        logic [31:0] rd;
        logic        e_req, e_we, e_busy, e_ia, e_da;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        logic [31:0] e_ir, e_dr;
    } vec_t;

    function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da, dwd,
                                input logic [3:0] be, input logic g, rv, input logic [31:0] rd,
                                input logic e_req, e_we, e_busy, e_ia, e_da,
                                input logic [31:0] e_addr, e_wd, input logic [3:0] e_be,
                                input logic [31:0] e_ir, e_dr);
        vec_t v;
        v = '{ir, dr, dw, ia, da, dwd, be, g, rv, rd,
              e_req, e_we, e_busy, e_ia, e_da, e_addr, e_wd, e_be, e_ir, e_dr};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, dr, dw, input logic [31:0] ia, da, dwd,
                         input logic [3:0] be, input logic g, rv, input logic [31:0] rd);
        i_req = ir; d_req = dr; d_we = dw; i_addr = ia; d_addr = da; d_wdata = dwd;
        d_byteen = be; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
    endtask

    vec_t v[14];
    localparam logic [31:0] IR = 32'h24010001;

    initial begin
        int exp_own[10];
        logic [1:0] own_q[$];
        int overlap, nreq, nbusy, nack;
        logic [11:0] pat_req, pat_ack;
        logic [4:0] r_req, r_ack;
        // single fetch, then a store and a load
        v[0]  = mk(1,0,0,'h3000,0,0,0, 0,0,0,          0,0,0,0,0, 0,0,0, 0,0);
        v[1]  = mk(1,0,0,'h3000,0,0,0, 1,0,0,          1,0,1,0,0, 'h3000,0,0, 0,0);
        v[2]  = mk(1,0,0,'h3000,0,0,0, 0,1,IR,         0,0,1,0,0, 0,0,0, 0,0);
        v[3]  = mk(0,0,0,0,0,0,0,       0,0,0,          0,0,1,1,0, 0,0,0, IR,0);
        v[4]  = mk(0,0,0,0,0,0,0,       0,0,0,          0,0,0,0,0, 0,0,0, IR,0);
        v[5]  = mk(0,1,1,0,'h10,'hAB00,'b0010, 0,0,0,   0,0,0,0,0, 0,0,0, IR,0);
        v[6]  = mk(0,1,1,0,'h10,'hAB00,'b0010, 1,1,'hDEADBEEF, 1,1,1,0,0, 'h10,'hAB00,'b0010, IR,0);
        v[7]  = mk(0,0,0,0,0,0,0,       0,1,'h55555555, 0,0,1,0,0, 0,0,0, IR,0);
        v[8]  = mk(0,0,0,0,0,0,0,       0,0,0,          0,0,1,0,1, 0,0,0, IR,0);
        v[9]  = mk(0,1,0,0,'h20,'hFFFFFFFF,'hF, 0,0,0,  0,0,0,0,0, 0,0,0, IR,0);
        v[10] = mk(0,1,0,0,'h20,'hFFFFFFFF,'hF, 1,0,0,  1,0,1,0,0, 'h20,0,0, IR,0);
        v[11] = mk(0,1,0,0,'h20,'hFFFFFFFF,'hF, 0,1,'hCAFEF00D, 0,0,1,0,0, 0,0,0, IR,0);
        v[12] = mk(0,0,0,0,0,0,0,       0,0,0,          0,0,1,0,1, 0,0,0, IR,'hCAFEF00D);
        v[13] = mk(0,0,0,0,0,0,0,       0,0,0,          0,0,0,0,0, 0,0,0, IR,'hCAFEF00D);
        exp_own = '{1,1,1,1,0,1,1,1,1,0};

        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst busy", busy, 0);
        chk("rst acks", {i_ack, d_ack}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst i_rdata", i_rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(v[i].ir, v[i].dr, v[i].dw, v[i].ia, v[i].da, v[i].dwd, v[i].be, v[i].g, v[i].rv, v[i].rd);
            #1;
            chk($sformatf("v%0d mem_req", i), mem_req, v[i].e_req);
            chk($sformatf("v%0d mem_we", i), mem_we, v[i].e_we);
            chk($sformatf("v%0d busy", i), busy, v[i].e_busy);
            chk($sformatf("v%0d i_ack", i), i_ack, v[i].e_ia);
            chk($sformatf("v%0d d_ack", i), d_ack, v[i].e_da);
            chk($sformatf("v%0d i_rdata", i), i_rdata, v[i].e_ir);
            chk($sformatf("v%0d d_rdata", i), d_rdata, v[i].e_dr);
            if (v[i].e_req) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr, v[i].e_addr);
                chk($sformatf("v%0d mem_byteen", i), mem_byteen, v[i].e_be);
            end
            if (v[i].e_we) chk($sformatf("v%0d mem_wdata", i), mem_wdata, v[i].e_wd);
        end

        // contention: both requests held, port always ready
        overlap = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) drive(1,1,0,'h100,'h200,0,0,1,1,0);
            #1;
            if (i_ack && d_ack) overlap++;
            if (d_ack) own_q.push_back(2'd1);
            else if (i_ack) own_q.push_back(2'd0);
        end
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0,0,0);
        for (int c = 0; c < 8 && busy; c++) @(negedge clk);
        chk("drain busy", busy, 0);
        chk("cont overlap", overlap, 0);
        chk("cont ack count", own_q.size(), 10);
        for (int k = 0; k < 10 && k < own_q.size(); k++)
            chk($sformatf("cont owner %0d", k), own_q[k], exp_own[k]);

        // stalled port with spurious rvalid before the grant
        nreq = 0; nbusy = 0; nack = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            drive(c < 11, 0, 0, 'h5000, 0, 0, 0, c == 6, c < 6 || c == 10,
                  c == 10 ? 32'h11112222 : 32'hBAD00BAD);
            #1;
            nreq += int'(mem_req);
            nbusy += int'(busy);
            nack += int'(i_ack) + int'(d_ack);
        end
        chk("stall mem_req cycles", nreq, 6);
        chk("stall busy cycles", nbusy, 11);
        chk("stall ack count", nack, 1);
        chk("stall i_rdata", i_rdata, 32'h11112222);

        // held fetch request: one issue per DONE->IDLE->REQ
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) drive(1,0,0,'h6000,0,0,0,1,1,'h600D);
            #1;
            pat_req[c] = mem_req;
            pat_ack[c] = i_ack;
        end
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0,0,0);
        chk("held mem_req pattern", pat_req, 12'h222);
        chk("held i_ack pattern", pat_ack, 12'h888);

        // reset while in WAIT
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) drive(1,0,0,'h4000,0,0,0,1,0,'h77);
            #1;
        end
        chk("wait busy", busy, 1);
        reset = 0;
        #1;
        chk("rstw mem_req", mem_req, 0);
        chk("rstw mem_we", mem_we, 0);
        chk("rstw busy", busy, 0);
        chk("rstw acks", {i_ack, d_ack}, 0);
        chk("rstw mem_addr", mem_addr, 0);
        chk("rstw mem_wdata", mem_wdata, 0);
        chk("rstw mem_byteen", mem_byteen, 0);
        chk("rstw i_rdata", i_rdata, 0);
        chk("rstw d_rdata", d_rdata, 0);
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            if (r == 0) begin
                reset = 1;
                drive(1,0,0,'h4000,0,0,0,1,1,'h77);
            end
            if (r == 3) drive(0,0,0,0,0,0,0,0,0,0);
            #1;
            r_req[r] = mem_req;
            r_ack[r] = i_ack;
            if (mem_req) chk("post-rst mem_addr", mem_addr, 'h4000);
        end
        chk("post-rst mem_req pattern", r_req, 5'b00010);
        chk("post-rst i_ack pattern", r_ack, 5'b01000);
        chk("post-rst i_rdata", i_rdata, 'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
